// File: rtl/raster_pkg.sv
// Shared definitions for the triangle record layout and the dispatcher state machine.
package raster_pkg;

   localparam int WORDS_PER_TRI = 10;

   localparam logic [3:0] W_P1X   = 4'd0;
   localparam logic [3:0] W_P1Y   = 4'd1;
   localparam logic [3:0] W_P1Z   = 4'd2;
   localparam logic [3:0] W_P2X   = 4'd3;
   localparam logic [3:0] W_P2Y   = 4'd4;
   localparam logic [3:0] W_P2Z   = 4'd5;
   localparam logic [3:0] W_P3X   = 4'd6;
   localparam logic [3:0] W_P3Y   = 4'd7;
   localparam logic [3:0] W_P3Z   = 4'd8;
   localparam logic [3:0] W_COLOR = 4'd9;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LAUNCH = 3'd2,
      WAIT   = 3'd3,
      FINISH = 3'd4
   } disp_state_t;

endpackage

// File: rtl/triangle_dispatcher.sv
// Walks a triangle list, fetching each 10-word record and handing it to the rasterizer.
// Start follows frame_start by 12 cycles; the next record is fetched only after done.
module triangle_dispatcher
   import raster_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              areset_n,
   input  logic              frame_start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  tri_count,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [2:0][31:0]  p1,
   output logic [2:0][31:0]  p2,
   output logic [2:0][31:0]  p3,
   output logic [3:0]        color,
   output logic              start,
   input  logic              done,
   output logic              busy,
   output logic              frame_done
);

   disp_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [3:0]        w_q, w_d;
   logic [3:0]        rd_idx_q, rd_idx_d;
   logic              rd_vld_q, rd_vld_d;
   logic [2:0][31:0]  p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
   logic [3:0]        color_q, color_d;
   logic              fetch_rd;

   assign fetch_rd = (state_q == FETCH) && (w_q <= W_COLOR);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      w_d      = w_q;
      rd_vld_d = fetch_rd;
      rd_idx_d = w_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      p3_d     = p3_q;
      color_d  = color_q;

      // Read data lags the request by one cycle, so route it by the word index of that request.
      if (rd_vld_q) begin
         case (rd_idx_q)
            W_P1X:   p1_d[0] = mem_rdata;
            W_P1Y:   p1_d[1] = mem_rdata;
            W_P1Z:   p1_d[2] = mem_rdata;
            W_P2X:   p2_d[0] = mem_rdata;
            W_P2Y:   p2_d[1] = mem_rdata;
            W_P2Z:   p2_d[2] = mem_rdata;
            W_P3X:   p3_d[0] = mem_rdata;
            W_P3Y:   p3_d[1] = mem_rdata;
            W_P3Z:   p3_d[2] = mem_rdata;
            W_COLOR: color_d = mem_rdata[3:0];
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               if (tri_count == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d = FETCH;
                  addr_d  = base_addr;
                  cnt_d   = tri_count;
                  idx_d   = '0;
                  w_d     = '0;
               end
            end
         end
         FETCH: begin
            if (fetch_rd) begin
               addr_d = addr_q + 1'b1;
               w_d    = w_q + 4'd1;
            end else begin
               state_d = LAUNCH;
            end
         end
         LAUNCH: state_d = WAIT;
         WAIT: begin
            if (done) begin
               if ((idx_q + 1'b1) == cnt_q) begin
                  state_d = FINISH;
               end else begin
                  state_d = FETCH;
                  idx_d   = idx_q + 1'b1;
                  w_d     = '0;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!areset_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         w_q      <= '0;
         rd_idx_q <= '0;
         rd_vld_q <= 1'b0;
         p1_q     <= '0;
         p2_q     <= '0;
         p3_q     <= '0;
         color_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         w_q      <= w_d;
         rd_idx_q <= rd_idx_d;
         rd_vld_q <= rd_vld_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         p3_q     <= p3_d;
         color_q  <= color_d;
      end
   end

   assign mem_re     = fetch_rd;
   assign mem_addr   = addr_q;
   assign p1         = p1_q;
   assign p2         = p2_q;
   assign p3         = p3_q;
   assign color      = color_q;
   assign start      = (state_q == LAUNCH);
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == FINISH);

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Randomized bench for triangle_dispatcher against a record-level memory and timing model.
module tb_triangle_dispatcher;

   logic             clk = 1'b0;
   logic             areset_n;
   logic             frame_start;
   logic [11:0]      base_addr;
   logic [8:0]       tri_count;
   logic             mem_re;
   logic [11:0]      mem_addr;
   logic [31:0]      mem_rdata = '0;
   logic [2:0][31:0] p1, p2, p3;
   logic [3:0]       color;
   logic             start;
   logic             done;
   logic             busy;
   logic             frame_done;

   logic [31:0] mem [0:4095];
   logic [11:0] aq [$];
   int cyc = 0;
   int n_start = 0;
   int n_fd = 0;
   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   triangle_dispatcher #(.ADDR_W(12), .CNT_W(9)) dut (
      .clk(clk), .areset_n(areset_n), .frame_start(frame_start),
      .base_addr(base_addr), .tri_count(tri_count),
      .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .p1(p1), .p2(p2), .p3(p3), .color(color),
      .start(start), .done(done), .busy(busy), .frame_done(frame_done)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   always @(negedge clk) begin
      if (mem_re) aq.push_back(mem_addr);
      if (start) n_start <= n_start + 1;
      if (frame_done) n_fd <= n_fd + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int widx(input int base, input int i, input int w);
      return (base + 10 * i + w) % 4096;
   endfunction

   task automatic chk_rec(input string tag, input int base, input int i);
      logic [31:0] got;
      logic [31:0] cw;
      for (int w = 0; w < 9; w++) begin
         case (w / 3)
            0:       got = p1[w % 3];
            1:       got = p2[w % 3];
            default: got = p3[w % 3];
         endcase
         chk(tag, got, mem[widx(base, i, w)]);
      end
      cw = mem[widx(base, i, 9)];
      chk({tag, "_color"}, 32'(color), 32'(cw[3:0]));
   endtask

   // Runs one frame; rst_i selects a triangle whose WAIT is interrupted by reset (-1 for none).
   task automatic run_frame(input int base, input int count, input int delay,
                            input bit spur, input int rst_i);
      int t0, t_done, exp_start, waited, e, s0, f0, bad;
      aq.delete();
      s0 = n_start;
      f0 = n_fd;
      t_done = 0;
      if (spur) begin
         done = 1'b1;
         @(negedge clk);
         done = 1'b0;
      end
      base_addr   = 12'(base);
      tri_count   = 9'(count);
      frame_start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      frame_start = 1'b0;
      base_addr   = 12'($urandom);
      tri_count   = 9'($urandom);
      exp_start   = t0 + 12;
      for (int i = 0; i < count; i++) begin
         waited = 0;
         while (!start && waited < 100) begin
            done = spur && (i == 0) && (cyc == t0 + 5);
            @(negedge clk);
            waited++;
         end
         done = 1'b0;
         chk("start_seen", 32'(start), 32'd1);
         if (!start) return;
         chk("start_cyc", cyc, exp_start);
         chk_rec("rec", base, i);
         done = spur && (i == 0);
         @(negedge clk);
         done = 1'b0;
         chk("start_pulse", 32'(start), 32'd0);
         frame_start = spur && (i == 0);
         @(negedge clk);
         frame_start = 1'b0;
         e = 2;
         if (i == rst_i) begin
            areset_n = 1'b0;
            @(negedge clk);
            areset_n = 1'b1;
            chk("rst_ctl", 32'({start, mem_re, busy, frame_done, color}), 32'd0);
            chk("rst_addr", 32'(mem_addr), 32'd0);
            chk("rst_p", 32'(|{p1, p2, p3}), 32'd0);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            repeat (20) @(negedge clk);
            chk("rst_nostart", n_start - s0, i + 1);
            chk("rst_idle", 32'(busy), 32'd0);
            return;
         end
         while (e < delay) begin
            @(negedge clk);
            e++;
         end
         chk_rec("hold", base, i);
         done   = 1'b1;
         t_done = cyc;
         @(negedge clk);
         done = 1'b0;
         exp_start = t_done + 12;
      end
      chk("frame_done", 32'(frame_done), 32'd1);
      chk("fd_cyc", cyc, t_done + 1);
      @(negedge clk);
      chk("fd_pulse", 32'({frame_done, busy}), 32'd0);
      @(negedge clk);
      chk("n_start", n_start - s0, count);
      chk("n_fd", n_fd - f0, 1);
      chk("addr_len", aq.size(), 10 * count);
      bad = 0;
      for (int k = 0; k < aq.size(); k++)
         if (int'(aq[k]) != (base + k) % 4096) bad++;
      chk("addr_seq", bad, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, t0;
      logic [31:0] dir [10];
      dir = '{32'h428a0000, 32'h428a0000, 32'h3f800000, 32'h428a0000, 32'h43290000,
              32'h3f800000, 32'h43290000, 32'h428a0000, 32'h3f800000, 32'h0000000A};
      areset_n    = 1'b0;
      frame_start = 1'b0;
      done        = 1'b0;
      base_addr   = '0;
      tri_count   = '0;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      repeat (3) @(negedge clk);
      chk("reset_ctl", 32'({start, mem_re, busy, frame_done, color}), 32'd0);
      chk("reset_addr", 32'(mem_addr), 32'd0);
      chk("reset_p", 32'(|{p1, p2, p3}), 32'd0);
      areset_n = 1'b1;
      @(negedge clk);

      for (int w = 0; w < 10; w++) mem[w] = dir[w];
      run_frame(0, 1, 20, 1'b0, -1);

      aq.delete();
      s0 = n_start;
      base_addr   = 12'h123;
      tri_count   = '0;
      frame_start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      frame_start = 1'b0;
      chk("empty_fd", 32'({frame_done, busy, mem_re, start}), 32'b1100);
      chk("empty_cyc", cyc, t0 + 1);
      @(negedge clk);
      chk("empty_end", 32'({frame_done, busy}), 32'd0);
      @(negedge clk);
      chk("empty_nostart", n_start - s0, 0);
      chk("empty_noread", aq.size(), 0);

      run_frame(12'h100, 3, $urandom_range(2, 30), 1'b0, -1);
      run_frame(int'($urandom_range(0, 4095)), 2, 10, 1'b1, -1);
      run_frame(12'h040, 3, 8, 1'b0, 1);
      run_frame(12'h200, 2, 5, 1'b0, -1);
      run_frame(12'hFFC, 1, 6, 1'b0, -1);
      for (int r = 0; r < 4; r++)
         run_frame(int'($urandom_range(0, 4095)), int'($urandom_range(1, 4)),
                   int'($urandom_range(2, 25)), 1'(r % 2), -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/triangle_dispatcher.md
Name: triangle_dispatcher

Overview:
Upstream feeder for rasterizer_unit. On a frame_start pulse it walks a triangle list in a synchronous word-addressed memory, loads each 10-word record (three raster-space IEEE-754 vertices plus colour) into output registers, pulses start to the rasterizer, and waits for its done before fetching the next record. It reports frame completion with a single-cycle pulse.

Parameters:
ADDR_W, 12, word-address width of the triangle memory
CNT_W, 9, width of the triangle-count input

Ports:
clk  in  1  system clock, all state changes on rising edge
areset_n  in  1  reset; synchronous, active-low
frame_start  in  1  one-cycle request to rasterize a triangle list; honoured only in IDLE
base_addr  in  ADDR_W  word address of the first record; sampled with frame_start
tri_count  in  CNT_W  number of triangles; sampled with frame_start
mem_re  out  1  memory read enable
mem_addr  out  ADDR_W  memory word address
mem_rdata  in  32  read data, valid exactly 1 cycle after the mem_re/mem_addr cycle
p1, p2, p3  out  32 x3 each  vertex {x,y,z} float32 in raster coordinates, index 0=x, 1=y, 2=z
color  out  4  triangle colour
start  out  1  one-cycle launch pulse to the rasterizer
done  in  1  one-cycle completion pulse from the rasterizer
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after the last triangle's done, or after an empty list

Behaviour:
- Record layout at base_addr + 10*i + w: w0..2 = p1 x,y,z; w3..5 = p2; w6..8 = p3; w9 = colour in bits [3:0], bits [31:4] ignored.
- Reset (areset_n=0 at a clock edge), from any state including mid-fetch or mid-wait: state IDLE. All outputs 0: p1/p2/p3, color, start, mem_re, mem_addr, busy, frame_done. Internal counters 0. A done arriving during or after reset is discarded.
- IDLE:
  - frame_start=1 with tri_count=0 -> FINISH.
  - frame_start=1 with tri_count>0 -> FETCH. Latch base_addr into the address counter and tri_count into the count register. Clear the triangle index.
- FETCH: 11 cycles, f0..f10, with word counter w.
  - f0..f9: mem_re=1, mem_addr = addr counter; the counter increments each cycle.
  - Data for word w is captured at the end of cycle f(w+1) into the matching output field.
  - f10: mem_re=0, colour captured -> LAUNCH.
  - The address counter runs continuously across records, so there is no multiplier. It wraps modulo 2^ADDR_W silently.
- LAUNCH: start=1 for exactly one cycle -> WAIT.
- WAIT: start=0. Outputs p1/p2/p3/color are held stable from LAUNCH until the next FETCH begins.
  - done=1 and index+1 == count -> FINISH.
  - done=1 otherwise -> index++, then FETCH of the next record.
- FINISH: frame_done=1 for one cycle -> IDLE.
- done is ignored in every state except WAIT. WAIT is first entered the cycle after start.
- frame_start is ignored while busy=1. A frame_start in the FINISH cycle is also dropped.
- Latency, with frame_start sampled at cycle 0:
  - FETCH cycles 1..11, start at cycle 12.
  - done at cycle t -> next start at t+12; if it was the last triangle, frame_done at t+1.
  - Empty list: frame_done at cycle 1.

Decomposition:
- Shared package raster_pkg holds WORDS_PER_TRI=10, word-index constants (W_P1X..W_COLOR), and the dispatcher state enum {IDLE, FETCH, LAUNCH, WAIT, FINISH}.
- Single module with no sub-module. Word capture is a case on the delayed word index.

Test Plan:
- Single triangle: base_addr=0, tri_count=1, memory w0..w9 = 428a0000, 428a0000, 3f800000, 428a0000, 43290000, 3f800000, 43290000, 428a0000, 3f800000, 0000000A. Rasterizer model pulses done 20 cycles after start. -> start exactly at cycle 12; p1/p2/p3 equal those words and color=4'hA at start; frame_done at done+1; busy low afterwards.
- tri_count=0 -> frame_done at cycle 1; mem_re and start never asserted.
- tri_count=3, base_addr=0x100 -> mem_addr covers 0x100..0x11D contiguously; three start pulses, each 12 cycles after the previous done; one frame_done.
- Spurious done pulses in IDLE, FETCH and LAUNCH, plus frame_start during WAIT -> no state change, no extra start, no restart.
- areset_n=0 for one cycle during WAIT of triangle 2 of 3 -> all outputs 0 the next cycle. A later done is ignored. A new frame_start refetches from the new base_addr, word 0.
- base_addr=0xFFC, tri_count=1 -> mem_addr sequence FFC, FFD, FFE, FFF, 000..005 (wrap); captured data matches.
